scarv_cop_palu_issue: RTL and testbench

- Issue and writeback controller that sits between the coprocessor decode stage and the packed ALU.
- Owns the 16-entry coprocessor register file (CPR) and accepts one decoded instruction at a time. It reads crs1/crs2/crs3, drives the PALU request and holds it stable until the PALU reports completion.
- On completion it writes the result into crd under byte enables, then signals completion upstream.
- Handles multi-cycle PALU ops (packed multiply) and bounds them with a timeout.

---
 rtl/scarv_cop_palu_issue_if.sv | 53 +++++
 rtl/scarv_cop_palu_issue.sv | 168 ++++++++++++++++
 tb/tb_scarv_cop_palu_issue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_palu_issue_if.sv
// rtl/scarv_cop_palu_issue_if.sv - decode/PALU handshake bundle for the coprocessor issue controller
//
// Purpose: groups the decode-side instruction handshake, the completion
// response and the packed-ALU request/writeback bus.
// master : issue controller view (takes id_*, palu_idone, palu_cpr_rd_*;
//          drives id_ready, cop_*, palu_* request fields)
// slave  : environment view (decode stage plus packed ALU)
interface scarv_cop_palu_issue_if;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_class;
    logic [3:0]  id_subclass;
    logic [2:0]  id_pw;
    logic [31:0] id_imm;
    logic [3:0]  id_crs1;
    logic [3:0]  id_crs2;
    logic [3:0]  id_crs3;
    logic [3:0]  id_crd;
    logic [31:0] id_gpr_rs1;
    logic        cop_done;
    logic        cop_err;
    logic [3:0]  cop_wb_ben;
    logic        palu_ivalid;
    logic        palu_idone;
    logic [2:0]  palu_class;
    logic [3:0]  palu_subclass;
    logic [2:0]  palu_pw;
    logic [31:0] palu_imm;
    logic [31:0] palu_gpr_rs1;
    logic [31:0] palu_rs1;
    logic [31:0] palu_rs2;
    logic [31:0] palu_rs3;
    logic [3:0]  palu_cpr_rd_ben;
    logic [31:0] palu_cpr_rd_wdata;

    modport master (
        input  id_valid, id_class, id_subclass, id_pw, id_imm,
               id_crs1, id_crs2, id_crs3, id_crd, id_gpr_rs1,
               palu_idone, palu_cpr_rd_ben, palu_cpr_rd_wdata,
        output id_ready, cop_done, cop_err, cop_wb_ben,
               palu_ivalid, palu_class, palu_subclass, palu_pw, palu_imm,
               palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3
    );

    modport slave (
        output id_valid, id_class, id_subclass, id_pw, id_imm,
               id_crs1, id_crs2, id_crs3, id_crd, id_gpr_rs1,
               palu_idone, palu_cpr_rd_ben, palu_cpr_rd_wdata,
        input  id_ready, cop_done, cop_err, cop_wb_ben,
               palu_ivalid, palu_class, palu_subclass, palu_pw, palu_imm,
               palu_gpr_rs1, palu_rs1, palu_rs2, palu_rs3
    );
endinterface

// File: rtl/scarv_cop_palu_issue.sv
// rtl/scarv_cop_palu_issue.sv - coprocessor issue/writeback controller owning the CPR file
//
// Purpose: accepts one decoded instruction at a time, latches its fields and
// CPR operands towards the packed ALU, holds them until palu_idone (or a
// timeout), then byte-writes the result into CPR[crd] and pulses cop_done.
// Ports:
//   g_clk    : clock, rising edge
//   g_resetn : asynchronous reset, active-high
//   bus      : scarv_cop_palu_issue_if.master (decode handshake, completion
//              response, PALU request and writeback)
module scarv_cop_palu_issue #(
    parameter int         TIMEOUT       = 255,
    parameter logic [2:0] CLASS_BITWISE = 3'b111
) (
    input  logic                          g_clk,
    input  logic                          g_resetn,
    scarv_cop_palu_issue_if.master        bus
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] cpr_q [16];
    logic [31:0] cpr_d [16];
    logic [2:0]  class_q, class_d;
    logic [3:0]  subclass_q, subclass_d;
    logic [2:0]  pw_q, pw_d;
    logic [31:0] imm_q, imm_d;
    logic [31:0] gpr_q, gpr_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] rs3_q, rs3_d;
    logic [3:0]  crd_q, crd_d;
    logic        err_q, err_d;
    logic [3:0]  wb_ben_q, wb_ben_d;

    // c0 is hardwired to zero on the read side; it is also never written.
    logic [31:0] rd_crs1, rd_crs2, rd_crs3, rd_crd;
    logic [3:0]  rs3_idx;

    always_comb begin
        rs3_idx = (bus.id_class == CLASS_BITWISE) ? bus.id_crd : bus.id_crs3;
        rd_crs1 = (bus.id_crs1 == 4'd0) ? 32'd0 : cpr_q[bus.id_crs1];
        rd_crs2 = (bus.id_crs2 == 4'd0) ? 32'd0 : cpr_q[bus.id_crs2];
        rd_crs3 = (rs3_idx     == 4'd0) ? 32'd0 : cpr_q[rs3_idx];
        rd_crd  = 32'd0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpr_d      = cpr_q;
        class_d    = class_q;
        subclass_d = subclass_q;
        pw_d       = pw_q;
        imm_d      = imm_q;
        gpr_d      = gpr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs3_d      = rs3_q;
        crd_d      = crd_q;
        err_d      = err_q;
        wb_ben_d   = wb_ben_q;

        case (state_q)
            // DONE accepts like IDLE: the EXEC writeback is already in cpr_q,
            // so operands read here see it without any bypass.
            S_IDLE, S_DONE: begin
                if (bus.id_valid) begin
                    class_d    = bus.id_class;
                    subclass_d = bus.id_subclass;
                    pw_d       = bus.id_pw;
                    imm_d      = bus.id_imm;
                    gpr_d      = bus.id_gpr_rs1;
                    rs1_d      = rd_crs1;
                    rs2_d      = rd_crs2;
                    rs3_d      = rd_crs3 | rd_crd;
                    crd_d      = bus.id_crd;
                    cnt_d      = 8'd0;
                    err_d      = 1'b0;
                    wb_ben_d   = 4'd0;
                    state_d    = S_EXEC;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_EXEC: begin
                // Completion wins over a timeout landing in the same cycle.
                if (bus.palu_idone) begin
                    if (crd_q != 4'd0) begin
                        for (int i = 0; i < 4; i++) begin
                            if (bus.palu_cpr_rd_ben[i]) begin
                                cpr_d[crd_q][8*i +: 8] = bus.palu_cpr_rd_wdata[8*i +: 8];
                            end
                        end
                    end
                    wb_ben_d = (crd_q == 4'd0) ? 4'd0 : bus.palu_cpr_rd_ben;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    wb_ben_d = 4'd0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_resetn) begin
        if (g_resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            for (int i = 0; i < 16; i++) cpr_q[i] <= 32'd0;
            class_q    <= 3'd0;
            subclass_q <= 4'd0;
            pw_q       <= 3'd0;
            imm_q      <= 32'd0;
            gpr_q      <= 32'd0;
            rs1_q      <= 32'd0;
            rs2_q      <= 32'd0;
            rs3_q      <= 32'd0;
            crd_q      <= 4'd0;
            err_q      <= 1'b0;
            wb_ben_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < 16; i++) cpr_q[i] <= cpr_d[i];
            class_q    <= class_d;
            subclass_q <= subclass_d;
            pw_q       <= pw_d;
            imm_q      <= imm_d;
            gpr_q      <= gpr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs3_q      <= rs3_d;
            crd_q      <= crd_d;
            err_q      <= err_d;
            wb_ben_q   <= wb_ben_d;
        end
    end

    // All handshake outputs decode straight from state flops.
    assign bus.id_ready      = (state_q != S_EXEC);
    assign bus.palu_ivalid   = (state_q == S_EXEC);
    assign bus.cop_done      = (state_q == S_DONE);
    assign bus.cop_err       = (state_q == S_DONE) & err_q;
    assign bus.cop_wb_ben    = (state_q == S_DONE) ? wb_ben_q : 4'd0;
    assign bus.palu_class    = class_q;
    assign bus.palu_subclass = subclass_q;
    assign bus.palu_pw       = pw_q;
    assign bus.palu_imm      = imm_q;
    assign bus.palu_gpr_rs1  = gpr_q;
    assign bus.palu_rs1      = rs1_q;
    assign bus.palu_rs2      = rs2_q;
    assign bus.palu_rs3      = rs3_q;

endmodule

// File: tb/tb_scarv_cop_palu_issue.sv
// tb/tb_scarv_cop_palu_issue.sv - directed self-checking bench for scarv_cop_palu_issue
module tb_scarv_cop_palu_issue;

    localparam logic [2:0] C_NONE    = 3'b000;
    localparam logic [2:0] C_ARITH   = 3'b001;
    localparam logic [2:0] C_MOVE    = 3'b101;
    localparam logic [2:0] C_BITWISE = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  id_class = '0;
    logic [3:0]  id_subclass = '0;
    logic [2:0]  id_pw = '0;
    logic [31:0] id_imm = '0;
    logic [3:0]  id_crs1 = '0, id_crs2 = '0, id_crs3 = '0, id_crd = '0;
    logic [31:0] id_gpr = '0;
    logic        palu_idone = 1'b0;
    logic [3:0]  palu_ben = '0;
    logic [31:0] palu_wdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scarv_cop_palu_issue_if b1();
    scarv_cop_palu_issue_if b2();

    assign b1.id_valid = id_valid & ~sel;         assign b2.id_valid = id_valid & sel;
    assign b1.id_class = id_class;                assign b2.id_class = id_class;
    assign b1.id_subclass = id_subclass;          assign b2.id_subclass = id_subclass;
    assign b1.id_pw = id_pw;                      assign b2.id_pw = id_pw;
    assign b1.id_imm = id_imm;                    assign b2.id_imm = id_imm;
    assign b1.id_crs1 = id_crs1;                  assign b2.id_crs1 = id_crs1;
    assign b1.id_crs2 = id_crs2;                  assign b2.id_crs2 = id_crs2;
    assign b1.id_crs3 = id_crs3;                  assign b2.id_crs3 = id_crs3;
    assign b1.id_crd = id_crd;                    assign b2.id_crd = id_crd;
    assign b1.id_gpr_rs1 = id_gpr;                assign b2.id_gpr_rs1 = id_gpr;
    assign b1.palu_idone = palu_idone;            assign b2.palu_idone = palu_idone;
    assign b1.palu_cpr_rd_ben = palu_ben;         assign b2.palu_cpr_rd_ben = palu_ben;
    assign b1.palu_cpr_rd_wdata = palu_wdata;     assign b2.palu_cpr_rd_wdata = palu_wdata;

    scarv_cop_palu_issue #(.TIMEOUT(255)) dut1 (.g_clk(clk), .g_resetn(rst), .bus(b1));
    scarv_cop_palu_issue #(.TIMEOUT(4))   dut2 (.g_clk(clk), .g_resetn(rst), .bus(b2));

    logic        o_ready, o_done, o_err, o_ivalid;
    logic [3:0]  o_wben;
    logic [31:0] o_rs1, o_rs2, o_rs3;
    logic [169:0] o_pf;

    assign o_ready  = sel ? b2.id_ready    : b1.id_ready;
    assign o_done   = sel ? b2.cop_done    : b1.cop_done;
    assign o_err    = sel ? b2.cop_err     : b1.cop_err;
    assign o_ivalid = sel ? b2.palu_ivalid : b1.palu_ivalid;
    assign o_wben   = sel ? b2.cop_wb_ben  : b1.cop_wb_ben;
    assign o_rs1    = sel ? b2.palu_rs1    : b1.palu_rs1;
    assign o_rs2    = sel ? b2.palu_rs2    : b1.palu_rs2;
    assign o_rs3    = sel ? b2.palu_rs3    : b1.palu_rs3;
    assign o_pf = sel ? {b2.palu_class, b2.palu_subclass, b2.palu_pw, b2.palu_imm,
                         b2.palu_gpr_rs1, b2.palu_rs1, b2.palu_rs2, b2.palu_rs3}
                      : {b1.palu_class, b1.palu_subclass, b1.palu_pw, b1.palu_imm,
                         b1.palu_gpr_rs1, b1.palu_rs1, b1.palu_rs2, b1.palu_rs3};

    // Results of the most recent run_op
    logic [31:0] res_rs1, res_rs2, res_rs3;
    int          res_exec;
    logic        res_done, res_err, res_stable, res_iv_done;
    logic [3:0]  res_wben;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, acts as the PALU (idone after idle_n EXEC
    // cycles with the given ben/wdata) and records what the controller did.
    task automatic run_op(input logic [2:0] cls, input logic [3:0] sub, input logic [2:0] pw,
                          input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                          input logic [3:0] d, input logic [31:0] gpr, input int idle_n,
                          input logic [3:0] ben, input logic [31:0] wdata);
        logic [169:0] pf0;
        id_class = cls; id_subclass = sub; id_pw = pw; id_imm = 32'h0000_1000 | {28'd0, d};
        id_crs1 = s1; id_crs2 = s2; id_crs3 = s3; id_crd = d; id_gpr = gpr;
        palu_idone = 1'b0;
        id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        res_rs1 = o_rs1; res_rs2 = o_rs2; res_rs3 = o_rs3; pf0 = o_pf;
        res_exec = 0; res_stable = 1'b1; res_done = 1'b0; res_err = 1'b0;
        res_wben = 4'd0; res_iv_done = 1'b0;
        for (int k = 0; k < 300 && !res_done; k++) begin
            if (o_ivalid) res_exec++;
            if (o_pf !== pf0) res_stable = 1'b0;
            if (res_exec > idle_n) begin
                palu_idone = 1'b1; palu_ben = ben; palu_wdata = wdata;
            end
            step();
            palu_idone = 1'b0; palu_ben = 4'd0; palu_wdata = 32'd0;
            if (o_done === 1'b1) begin
                res_done = 1'b1; res_wben = o_wben; res_err = o_err; res_iv_done = o_ivalid;
            end
        end
    endtask

    task automatic load(input logic [3:0] idx, input logic [31:0] val);
        run_op(C_MOVE, 4'h0, 3'd0, 4'd0, 4'd0, 4'd0, idx, val, 0, 4'hF, val);
    endtask

    task automatic read_cpr(input logic [3:0] idx, output logic [31:0] val);
        run_op(C_NONE, 4'h0, 3'd0, idx, 4'd0, 4'd0, 4'd0, 32'd0, 0, 4'h0, 32'd0);
        val = res_rs1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready dut%0d: got %b want 1", s, o_ready); end
            checks++; if (o_ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid dut%0d: got %b want 0", s, o_ivalid); end
            checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", s, o_done); end
            checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", s, o_err); end
            checks++; if (o_wben !== 4'd0) begin errors++; $display("FAIL reset_wben dut%0d: got %h want 0", s, o_wben); end
            checks++; if (o_pf !== 170'd0) begin errors++; $display("FAIL reset_palu_fields dut%0d: got %h want 0", s, o_pf); end
        end
        sel = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_add();
        logic [31:0] a, b, sum, rd;
        a = 32'h0001_0002; b = 32'h0003_0004;
        sum = {a[31:16] + b[31:16], a[15:0] + b[15:0]};
        load(4'd1, a);
        checks++; if (res_wben !== 4'hF) begin errors++; $display("FAIL mv2cop_wben: got %h want f", res_wben); end
        load(4'd2, b);
        run_op(C_ARITH, 4'h1, 3'd1, 4'd1, 4'd2, 4'd0, 4'd3, 32'd0, 0, 4'hF, sum);
        checks++; if (res_rs1 !== a) begin errors++; $display("FAIL add_rs1: got %h want %h", res_rs1, a); end
        checks++; if (res_rs2 !== b) begin errors++; $display("FAIL add_rs2: got %h want %h", res_rs2, b); end
        checks++; if (res_exec !== 1) begin errors++; $display("FAIL add_ivalid_cycles: got %0d want 1", res_exec); end
        checks++; if (res_done !== 1'b1) begin errors++; $display("FAIL add_done: got %b want 1", res_done); end
        checks++; if (res_wben !== 4'hF) begin errors++; $display("FAIL add_wben: got %h want f", res_wben); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", res_err); end
        checks++; if (res_iv_done !== 1'b0) begin errors++; $display("FAIL add_ivalid_in_done: got %b want 0", res_iv_done); end
        read_cpr(4'd3, rd);
        checks++; if (rd !== 32'h0004_0006) begin errors++; $display("FAIL add_cpr3: got %h want 00040006", rd); end
    endtask

    task automatic test_cmov();
        logic [31:0] rd;
        load(4'd2, 32'd5);
        load(4'd4, 32'hDEAD_BEEF);
        run_op(C_MOVE, 4'h2, 3'd0, 4'd0, 4'd2, 4'd0, 4'd4, 32'd0, 0, 4'h0, 32'h1234_5678);
        checks++; if (res_rs2 !== 32'd5) begin errors++; $display("FAIL cmov_rs2: got %h want 5", res_rs2); end
        checks++; if (res_done !== 1'b1) begin errors++; $display("FAIL cmov_done: got %b want 1", res_done); end
        checks++; if (res_wben !== 4'h0) begin errors++; $display("FAIL cmov_wben: got %h want 0", res_wben); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL cmov_err: got %b want 0", res_err); end
        read_cpr(4'd4, rd);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cmov_cpr4: got %h want deadbeef", rd); end
    endtask

    task automatic test_multicycle();
        logic [31:0] rd;
        load(4'd1, 32'h0001_0002);
        load(4'd2, 32'h0003_0004);
        run_op(C_ARITH, 4'h4, 3'd1, 4'd1, 4'd2, 4'd0, 4'd6, 32'd0, 17, 4'hF, 32'h0003_0008);
        checks++; if (res_exec !== 18) begin errors++; $display("FAIL mul_exec_cycles: got %0d want 18", res_exec); end
        checks++; if (res_stable !== 1'b1) begin errors++; $display("FAIL mul_palu_stable: got %b want 1", res_stable); end
        checks++; if (res_done !== 1'b1 || res_wben !== 4'hF || res_err !== 1'b0) begin errors++; $display("FAIL mul_completion: got done=%b ben=%h err=%b want 1 f 0", res_done, res_wben, res_err); end
        read_cpr(4'd6, rd);
        checks++; if (rd !== 32'h0003_0008) begin errors++; $display("FAIL mul_cpr6: got %h want 00030008", rd); end
        run_op(C_ARITH, 4'h1, 3'd0, 4'd0, 4'd0, 4'd0, 4'd6, 32'd0, 0, 4'b1010, 32'hA1B2_C3D4);
        checks++; if (res_wben !== 4'b1010) begin errors++; $display("FAIL partial_wben: got %h want a", res_wben); end
        read_cpr(4'd6, rd);
        checks++; if (rd !== 32'hA103_C308) begin errors++; $display("FAIL partial_cpr6: got %h want a103c308", rd); end
    endtask

    task automatic test_rs3_select();
        load(4'd8, 32'h8888_8888);
        load(4'd9, 32'h9999_9999);
        run_op(C_BITWISE, 4'h3, 3'd0, 4'd0, 4'd0, 4'd8, 4'd9, 32'd0, 0, 4'h0, 32'd0);
        checks++; if (res_rs3 !== 32'h9999_9999) begin errors++; $display("FAIL bitwise_rs3: got %h want 99999999", res_rs3); end
        run_op(C_ARITH, 4'h3, 3'd0, 4'd0, 4'd0, 4'd8, 4'd9, 32'd0, 0, 4'h0, 32'd0);
        checks++; if (res_rs3 !== 32'h8888_8888) begin errors++; $display("FAIL arith_rs3: got %h want 88888888", res_rs3); end
        run_op(3'b110, 4'hF, 3'd7, 4'd8, 4'd9, 4'd0, 4'd9, 32'd0, 0, 4'h0, 32'hFFFF_FFFF);
        checks++; if (res_done !== 1'b1 || res_wben !== 4'h0 || res_err !== 1'b0) begin errors++; $display("FAIL unknown_class: got done=%b ben=%h err=%b want 1 0 0", res_done, res_wben, res_err); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        sel = 1'b1;
        #1;
        run_op(C_ARITH, 4'h4, 3'd1, 4'd0, 4'd0, 4'd0, 4'd1, 32'd0, 1000, 4'hF, 32'hFFFF_FFFF);
        checks++; if (res_exec !== 4) begin errors++; $display("FAIL timeout_exec_cycles: got %0d want 4", res_exec); end
        checks++; if (res_done !== 1'b1 || res_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got done=%b err=%b want 1 1", res_done, res_err); end
        checks++; if (res_wben !== 4'h0) begin errors++; $display("FAIL timeout_wben: got %h want 0", res_wben); end
        read_cpr(4'd1, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL timeout_cpr1: got %h want 0", rd); end
        run_op(C_ARITH, 4'h4, 3'd1, 4'd0, 4'd0, 4'd0, 4'd1, 32'd0, 3, 4'hF, 32'h1122_3344);
        checks++; if (res_exec !== 4 || res_err !== 1'b0 || res_wben !== 4'hF) begin errors++; $display("FAIL idone_priority: got exec=%0d err=%b ben=%h want 4 0 f", res_exec, res_err, res_wben); end
        read_cpr(4'd1, rd);
        checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL priority_cpr1: got %h want 11223344", rd); end
        sel = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        run_op(C_ARITH, 4'h1, 3'd0, 4'd0, 4'd0, 4'd0, 4'd5, 32'd0, 0, 4'hF, 32'h0BAD_F00D);
        checks++; if (o_done !== 1'b1 || o_ready !== 1'b1) begin errors++; $display("FAIL done_ready: got done=%b ready=%b want 1 1", o_done, o_ready); end
        run_op(C_ARITH, 4'h1, 3'd0, 4'd5, 4'd0, 4'd0, 4'd0, 32'd0, 0, 4'h0, 32'd0);
        checks++; if (res_rs1 !== 32'h0BAD_F00D) begin errors++; $display("FAIL raw_rs1: got %h want 0badf00d", res_rs1); end
        checks++; if (res_exec !== 1 || res_done !== 1'b1) begin errors++; $display("FAIL b2b_latency: got exec=%0d done=%b want 1 1", res_exec, res_done); end
    endtask

    task automatic test_reset_mid_exec_c0();
        logic [31:0] rd;
        logic        seen;
        load(4'd7, 32'h7777_7777);
        id_class = C_ARITH; id_crs1 = 4'd7; id_crd = 4'd7; id_valid = 1'b1;
        step();
        id_valid = 1'b0;
        checks++; if (o_ivalid !== 1'b1) begin errors++; $display("FAIL midexec_ivalid: got %b want 1", o_ivalid); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (o_ivalid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL async_reset: got ivalid=%b ready=%b want 0 1", o_ivalid, o_ready); end
        palu_idone = 1'b1; palu_ben = 4'hF; palu_wdata = 32'hCCCC_CCCC;
        step();
        rst = 1'b0;
        palu_idone = 1'b0; palu_ben = 4'h0; palu_wdata = 32'd0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (o_done !== 1'b0) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done: got %b want 0", seen); end
        read_cpr(4'd7, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_cpr7: got %h want 0", rd); end
        run_op(C_ARITH, 4'h1, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0, 0, 4'hF, 32'hFFFF_FFFF);
        checks++; if (res_done !== 1'b1 || res_wben !== 4'h0) begin errors++; $display("FAIL c0_wben: got done=%b ben=%h want 1 0", res_done, res_wben); end
        read_cpr(4'd0, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL c0_read: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_cmov();
        test_multicycle();
        test_rs3_select();
        test_timeout();
        test_back_to_back();
        test_reset_mid_exec_c0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
